two_number_window_accum: RTL and testbench
==========================================

// Module: two_number_window_accum
// PURPOSE
//  Downstream consumer of the two_number sum/difference stage: accepts a stream of (a,b) fixed-point
//  pairs over a valid/ready handshake, aligns each to a common output exponent, and accumulates
//  N samples per window with saturation. Emits one (a_sum,b_sum) result per window, held until accepted.
//  Sits between the combinational add/sub stage and the sampled measurement/readout logic.
// PARAMETERS
//  A_WIDTH     18   significand width of input a (signed)
//  A_EXPONENT  -10  exponent of input a (value = code * 2**A_EXPONENT)
//  B_WIDTH     19   significand width of input b (signed)
//  B_EXPONENT  -11  exponent of input b
//  OUT_WIDTH   24   significand width of both accumulators/outputs (signed)
//  OUT_EXPONENT -10 exponent of both outputs
//  N           4    samples per window, >= 1
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rst        in   1          asynchronous, active-high reset
//  in_valid   in   1          input pair valid
//  in_ready   out  1          block can accept a pair this cycle
//  a_in       in   A_WIDTH    signed code of a
//  b_in       in   B_WIDTH    signed code of b
//  out_valid  out  1          window result valid
//  out_ready  in   1          downstream accepts result
//  a_sum      out  OUT_WIDTH  windowed sum of a at OUT_EXPONENT
//  b_sum      out  OUT_WIDTH  windowed sum of b at OUT_EXPONENT
//  a_ovf      out  1          a accumulator saturated at least once in this window
//  b_ovf      out  1          b accumulator saturated at least once in this window
// BEHAVIOUR
//  - Reset (async): state=ACCUM, count=0, accumulators=0, out_valid=0, a_sum=b_sum=0, ovf=0;
//    in_ready forced 0 while rst high.
//  - Align: shift = in_exp - OUT_EXPONENT; shift>0 -> arithmetic left shift; shift<0 -> arithmetic
//    right shift (floor, toward -inf). Sign-extend to OUT_WIDTH+1 before add.
//  - Add: acc + aligned; result outside [-2**(OUT_WIDTH-1), 2**(OUT_WIDTH-1)-1] clamps to the bound
//    and sets the lane's sticky ovf; aligned values that overflow OUT_WIDTH also clamp/flag.
//  - Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
//  - FSM ACCUM: in_ready=1, out_valid=0. Each transfer in: acc+=aligned, count++. On the Nth transfer:
//    a_sum/b_sum/ovf load the final sums (incl. that sample), acc/count/sticky clear, -> HOLD.
//  - FSM HOLD: out_valid=1, outputs stable; in_ready = out_ready (combinational).
//    Transfer out without transfer in -> ACCUM. Transfer out with transfer in -> sample starts the
//    new window (count=1); if N==1 the outputs reload with it and the FSM stays in HOLD.
//  - Latency: result visible the cycle after the Nth transfer in. Throughput: 1 pair/cycle when
//    out_ready is held high.
//  - out_ready while out_valid=0 is ignored. in_valid with in_ready=0 is held off (no loss).
// STRUCTURE
//  - Package two_number_window_accum_pkg: state_t enum {ACCUM,HOLD}; function sat_clamp(value,width);
//    localparam helpers for count width ($clog2(N+1)).
//  - Sub-module svreal_sat_accum_lane (x2, one per channel): align + saturating add + sticky ovf,
//    parameterised by IN_WIDTH/IN_EXPONENT/OUT_WIDTH/OUT_EXPONENT; the top holds FSM, count, output regs.
// TESTING
//  1. N=4, a_in=100, b_in=101 x4, out_ready=1 -> a_sum=400, b_sum=200 (101>>1=50), ovf=0, out_valid 1 cycle.
//  2. N=4, b_in=-3 x4 -> b_sum=-8 (floor: -3>>1=-2); a_in=-7 x4 -> a_sum=-28.
//  3. OUT_WIDTH=12, a_in=1000 x4 -> a_sum=2047, a_ovf=1; next window a_in=1 x4 -> a_sum=4, a_ovf=0.
//  4. Back-pressure: out_ready=0 for 5 cycles after a result, in_valid=1 -> in_ready=0, outputs stable;
//     out_ready=1 -> same-cycle transfer in counted as sample 1 of next window.
//  5. Reset mid-window: 2 samples of a_in=50, pulse rst async -> all outputs 0; then 4 x a_in=10 -> a_sum=40.
//  6. N=1, continuous in_valid with out_ready=1 -> one result per cycle, each equal to its aligned input.

Source files
------------

// File: rtl/two_number_window_accum_pkg.sv
// Shared types and helpers for the windowed two-lane saturating accumulator.
package two_number_window_accum_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Wide enough to hold any aligned input or OUT_WIDTH+1 sum without wrap.
    localparam int CALC_W = 64;

    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_clamp(
        input logic signed [CALC_W-1:0] value,
        input int                       width
    );
        logic signed [CALC_W-1:0] max_v;
        logic signed [CALC_W-1:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/two_number_window_accum_lane.sv
// One channel: align to the output exponent, saturating add into the window
// accumulator, and track whether any clamp happened in the current window.
module svreal_sat_accum_lane
    import two_number_window_accum_pkg::*;
#(
    parameter int IN_WIDTH     = 18,
    parameter int IN_EXPONENT  = -10,
    parameter int OUT_WIDTH    = 24,
    parameter int OUT_EXPONENT = -10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        add_en,
    input  logic                        last,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic signed [OUT_WIDTH-1:0] sum_o,
    output logic                        win_ovf_o
);

    localparam int SHIFT = IN_EXPONENT - OUT_EXPONENT;

    logic signed [CALC_W-1:0]    ext_s;
    logic signed [CALC_W-1:0]    aligned_s;
    logic signed [CALC_W-1:0]    aligned_sat_s;
    logic signed [CALC_W-1:0]    sum_wide_s;
    logic signed [CALC_W-1:0]    sum_sat_s;
    logic                        ovf_now_s;
    logic signed [OUT_WIDTH-1:0] acc_q;
    logic signed [OUT_WIDTH-1:0] acc_d;
    logic                        sticky_q;
    logic                        sticky_d;

    assign ext_s = CALC_W'(in_data);

    // Right shift is arithmetic, so negative codes round toward -inf.
    generate
        if (SHIFT >= 0) begin : g_lsh
            assign aligned_s = ext_s <<< SHIFT;
        end else begin : g_rsh
            assign aligned_s = ext_s >>> (-SHIFT);
        end
    endgenerate

    always_comb begin
        aligned_sat_s = sat_clamp(aligned_s, OUT_WIDTH);
        sum_wide_s    = CALC_W'(acc_q) + aligned_sat_s;
        sum_sat_s     = sat_clamp(sum_wide_s, OUT_WIDTH);
        ovf_now_s     = (aligned_sat_s != aligned_s) || (sum_sat_s != sum_wide_s);
        sum_o         = OUT_WIDTH'(sum_sat_s);
        win_ovf_o     = sticky_q | ovf_now_s;
    end

    // The closing sample of a window leaves the lane empty for the next one.
    always_comb begin
        acc_d    = acc_q;
        sticky_d = sticky_q;
        if (add_en) begin
            if (last) begin
                acc_d    = {OUT_WIDTH{1'b0}};
                sticky_d = 1'b0;
            end else begin
                acc_d    = sum_o;
                sticky_d = win_ovf_o;
            end
        end else begin
            acc_d    = acc_q;
            sticky_d = sticky_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= {OUT_WIDTH{1'b0}};
            sticky_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: rtl/two_number_window_accum.sv
// Windowed accumulator for (a,b) pairs: N samples per window, one held result
// per window over a valid/ready handshake.
module two_number_window_accum
    import two_number_window_accum_pkg::*;
#(
    parameter int A_WIDTH      = 18,
    parameter int A_EXPONENT   = -10,
    parameter int B_WIDTH      = 19,
    parameter int B_EXPONENT   = -11,
    parameter int OUT_WIDTH    = 24,
    parameter int OUT_EXPONENT = -10,
    parameter int N            = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [A_WIDTH-1:0]   a_in,
    input  logic signed [B_WIDTH-1:0]   b_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] a_sum,
    output logic signed [OUT_WIDTH-1:0] b_sum,
    output logic                        a_ovf,
    output logic                        b_ovf
);

    localparam int CNT_W = count_width(N);

    state_t                      state_q;
    state_t                      state_d;
    logic [CNT_W-1:0]            count_q;
    logic [CNT_W-1:0]            count_d;
    logic signed [OUT_WIDTH-1:0] a_sum_q;
    logic signed [OUT_WIDTH-1:0] a_sum_d;
    logic signed [OUT_WIDTH-1:0] b_sum_q;
    logic signed [OUT_WIDTH-1:0] b_sum_d;
    logic                        a_ovf_q;
    logic                        a_ovf_d;
    logic                        b_ovf_q;
    logic                        b_ovf_d;

    logic                        in_ready_s;
    logic                        out_valid_s;
    logic                        xfer_in_s;
    logic                        xfer_out_s;
    logic                        last_s;
    logic signed [OUT_WIDTH-1:0] a_lane_sum_s;
    logic signed [OUT_WIDTH-1:0] b_lane_sum_s;
    logic                        a_lane_ovf_s;
    logic                        b_lane_ovf_s;

    assign xfer_in_s  = in_valid & in_ready_s;
    assign xfer_out_s = out_valid_s & out_ready;
    assign last_s     = xfer_in_s && (count_q == CNT_W'(N - 1));

    svreal_sat_accum_lane #(
        .IN_WIDTH    (A_WIDTH),
        .IN_EXPONENT (A_EXPONENT),
        .OUT_WIDTH   (OUT_WIDTH),
        .OUT_EXPONENT(OUT_EXPONENT)
    ) u_lane_a (
        .clk      (clk),
        .rst      (rst),
        .add_en   (xfer_in_s),
        .last     (last_s),
        .in_data  (a_in),
        .sum_o    (a_lane_sum_s),
        .win_ovf_o(a_lane_ovf_s)
    );

    svreal_sat_accum_lane #(
        .IN_WIDTH    (B_WIDTH),
        .IN_EXPONENT (B_EXPONENT),
        .OUT_WIDTH   (OUT_WIDTH),
        .OUT_EXPONENT(OUT_EXPONENT)
    ) u_lane_b (
        .clk      (clk),
        .rst      (rst),
        .add_en   (xfer_in_s),
        .last     (last_s),
        .in_data  (b_in),
        .sum_o    (b_lane_sum_s),
        .win_ovf_o(b_lane_ovf_s)
    );

    // While holding a result, a new sample may only enter together with its acceptance.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready_s  = ~rst;
                out_valid_s = 1'b0;
            end
            HOLD: begin
                in_ready_s  = out_ready & ~rst;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // With N==1 an accepted result can be replaced by the sample arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: begin
                if (last_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = ACCUM;
                end
            end
            HOLD: begin
                if (xfer_out_s && !last_s) begin
                    state_d = ACCUM;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        a_sum_d = a_sum_q;
        b_sum_d = b_sum_q;
        a_ovf_d = a_ovf_q;
        b_ovf_d = b_ovf_q;
        if (last_s) begin
            count_d = {CNT_W{1'b0}};
            a_sum_d = a_lane_sum_s;
            b_sum_d = b_lane_sum_s;
            a_ovf_d = a_lane_ovf_s;
            b_ovf_d = b_lane_ovf_s;
        end else if (xfer_in_s) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            count_q <= {CNT_W{1'b0}};
            a_sum_q <= {OUT_WIDTH{1'b0}};
            b_sum_q <= {OUT_WIDTH{1'b0}};
            a_ovf_q <= 1'b0;
            b_ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_sum_q <= a_sum_d;
            b_sum_q <= b_sum_d;
            a_ovf_q <= a_ovf_d;
            b_ovf_q <= b_ovf_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign a_sum     = a_sum_q;
    assign b_sum     = b_sum_q;
    assign a_ovf     = a_ovf_q;
    assign b_ovf     = b_ovf_q;

endmodule

// File: tb/tb_two_number_window_accum.sv
// Directed bench: default, narrow-output and single-sample-window instances
// share one stimulus bus; each section checks the instance it targets.
module tb_two_number_window_accum;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic out_ready;
    logic signed [17:0] a_in;
    logic signed [18:0] b_in;

    logic               in_ready, out_valid, a_ovf, b_ovf;
    logic signed [23:0] a_sum, b_sum;
    logic               w_in_ready, w_out_valid, w_a_ovf, w_b_ovf;
    logic signed [11:0] w_a_sum, w_b_sum;
    logic               n_in_ready, n_out_valid, n_a_ovf, n_b_ovf;
    logic signed [23:0] n_a_sum, n_b_sum;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int a;
        int b;
        int ea;
        int eb;
    } vec_t;
    vec_t vecs[6];

    int t6_a[3]  = '{5, -3, 100};
    int t6_b[3]  = '{6, -3, 7};
    int t6_eb[3] = '{3, -2, 3};

    always #5 clk = ~clk;

    two_number_window_accum dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .a_sum(a_sum), .b_sum(b_sum), .a_ovf(a_ovf), .b_ovf(b_ovf)
    );

    two_number_window_accum #(.OUT_WIDTH(12)) dut_w12 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .a_in(a_in), .b_in(b_in), .out_valid(w_out_valid), .out_ready(out_ready),
        .a_sum(w_a_sum), .b_sum(w_b_sum), .a_ovf(w_a_ovf), .b_ovf(w_b_ovf)
    );

    two_number_window_accum #(.N(1)) dut_n1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
        .a_in(a_in), .b_in(b_in), .out_valid(n_out_valid), .out_ready(out_ready),
        .a_sum(n_a_sum), .b_sum(n_b_sum), .a_ovf(n_a_ovf), .b_ovf(n_b_ovf)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int a, input int b, input logic v);
        in_valid = v;
        a_in     = 18'(a);
        b_in     = 19'(b);
    endtask

    task automatic feed(input int a, input int b, input int k);
        drive(a, b, 1'b1);
        repeat (k) @(negedge clk);
        drive(0, 0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(0, 0, 1'b0);

        vecs[0] = '{100, 101, 400, 200};
        vecs[1] = '{-7, -3, -28, -8};
        vecs[2] = '{0, 0, 0, 0};
        vecs[3] = '{131071, 262143, 524284, 524284};
        vecs[4] = '{-131072, -262144, -524288, -524288};
        vecs[5] = '{1, -1, 4, -4};

        // Reset state
        @(negedge clk);
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst a_sum", a_sum, 0);
        chk("rst b_sum", b_sum, 0);
        chk("rst a_ovf", a_ovf, 0);
        chk("rst b_ovf", b_ovf, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle in_ready", in_ready, 1);

        // Table: one full window per record, result accepted immediately
        for (int i = 0; i < 6; i++) begin
            feed(vecs[i].a, vecs[i].b, 4);
            chk($sformatf("vec%0d out_valid", i), out_valid, 1);
            chk($sformatf("vec%0d a_sum", i), a_sum, vecs[i].ea);
            chk($sformatf("vec%0d b_sum", i), b_sum, vecs[i].eb);
            chk($sformatf("vec%0d a_ovf", i), a_ovf, 0);
            chk($sformatf("vec%0d b_ovf", i), b_ovf, 0);
            @(negedge clk);
            chk($sformatf("vec%0d out_valid drop", i), out_valid, 0);
        end

        // Saturation on 12-bit output, then sticky flag clears next window
        do_reset();
        feed(1000, 0, 4);
        chk("sat out_valid", w_out_valid, 1);
        chk("sat a_sum", w_a_sum, 2047);
        chk("sat a_ovf", w_a_ovf, 1);
        chk("sat b_sum", w_b_sum, 0);
        chk("sat b_ovf", w_b_ovf, 0);
        chk("sat in_ready", w_in_ready, 1);
        @(negedge clk);
        feed(1, 0, 4);
        chk("sat2 a_sum", w_a_sum, 4);
        chk("sat2 a_ovf", w_a_ovf, 0);

        // Back-pressure: result held, input stalled, handshake cycle starts next window
        do_reset();
        out_ready = 1'b0;
        drive(10, 20, 1'b1);
        repeat (4) @(negedge clk);
        chk("bp out_valid", out_valid, 1);
        chk("bp a_sum", a_sum, 40);
        chk("bp b_sum", b_sum, 40);
        drive(7, 14, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp stall%0d in_ready", i), in_ready, 0);
            chk($sformatf("bp stall%0d out_valid", i), out_valid, 1);
            chk($sformatf("bp stall%0d a_sum", i), a_sum, 40);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", in_ready, 1);
        @(negedge clk);
        chk("bp accepted out_valid", out_valid, 0);
        repeat (3) @(negedge clk);
        drive(0, 0, 1'b0);
        chk("bp next out_valid", out_valid, 1);
        chk("bp next a_sum", a_sum, 28);
        chk("bp next b_sum", b_sum, 28);

        // Asynchronous reset in the middle of a window
        do_reset();
        feed(3, 0, 4);
        chk("mid prior a_sum", a_sum, 12);
        @(negedge clk);
        feed(50, 0, 2);
        #2 rst = 1'b1;
        #1;
        chk("mid rst a_sum", a_sum, 0);
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst in_ready", in_ready, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        feed(10, 0, 4);
        chk("mid after out_valid", out_valid, 1);
        chk("mid after a_sum", a_sum, 40);

        // N=1: back-to-back windows, one result per cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(t6_a[i], t6_b[i], 1'b1);
            @(negedge clk);
            chk($sformatf("n1 s%0d out_valid", i), n_out_valid, 1);
            chk($sformatf("n1 s%0d in_ready", i), n_in_ready, 1);
            chk($sformatf("n1 s%0d a_sum", i), n_a_sum, t6_a[i]);
            chk($sformatf("n1 s%0d b_sum", i), n_b_sum, t6_eb[i]);
            chk($sformatf("n1 s%0d ovf", i), {n_a_ovf, n_b_ovf}, 0);
        end
        drive(0, 0, 1'b0);
        @(negedge clk);
        chk("n1 drain out_valid", n_out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
